// File: rtl/fde_sequencer.sv
// fde_sequencer
//   Multi-cycle fetch/decode/execute sequencer for the 16-bit processor.
//   Each instruction goes through FETCH, DECODE and EXEC. Loads and stores
//   also pass through MEM, and loads then pass through WB. The block owns the
//   single shared memory port. Instruction fetch and data access share it
//   through a req/ack handshake, with an optional wait-cycle timeout that
//   sends the sequencer to FAULT.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   en                 run enable, sampled in IDLE and at instruction boundaries
//   instr[15:0]        IR contents; the opcode is instr[15:12]
//   zero_flag          Z flag, selects the BEQ target
//   mem_ack            memory finished the current request this cycle
//   mem_req/we/sel     memory request strobe, write strobe, address/data select
//   ir_load, pc_inc    IR load and PC update pulses
//   pc_sel, immed_sel  PC source and ALU B operand source
//   alu_func[3:0]      ALU operation
//   flag_en, w_en      flag latch enable and register-file write enable
//   state[2:0]         current state (IDLE=0 .. FAULT=7)
//   halted, fault      high while in HALT / FAULT
//
// The strobes are decoded from the registered state and the latched opcode.
// This keeps them glitch-free with respect to the instruction inputs. ir_load
// and the STR pc_inc in MEM are the exceptions: they are gated by mem_ack so
// that they fire on the handshake cycle itself.
module fde_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] instr,
  input  logic        zero_flag,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_sel,
  output logic        immed_sel,
  output logic [3:0]  alu_func,
  output logic        flag_en,
  output logic        w_en,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'h0;
  localparam logic [3:0] OP_ADDS = 4'h1;
  localparam logic [3:0] OP_SUBS = 4'h2;
  localparam logic [3:0] OP_ANDS = 4'h3;
  localparam logic [3:0] OP_ORRS = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_ORR  = 4'b0100;

  state_t      state_r;
  logic [3:0]  opcode_r;
  logic [15:0] wait_cnt_r;
  logic        timeout_hit;
  state_t      boundary_next;

  // A request times out on the last allowed wait cycle. An ack in that same cycle still wins.
  always_comb begin
    if (TIMEOUT == 0) begin
      timeout_hit = 1'b0;
    end else begin
      timeout_hit = !mem_ack && (wait_cnt_r == 16'(TIMEOUT - 1));
    end
  end

  // Where to go once an instruction completes: start the next one or park in IDLE.
  always_comb begin
    if (en) begin
      boundary_next = S_FETCH;
    end else begin
      boundary_next = S_IDLE;
    end
  end

  // State register, latched opcode and memory wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      opcode_r   <= 4'h0;
      wait_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (en) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 16'd0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            state_r    <= S_DECODE;
            wait_cnt_r <= 16'd0;
          end else if (timeout_hit) begin
            state_r    <= S_FAULT;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        S_DECODE: begin
          opcode_r <= instr[15:12];
          if (instr[15:12] == OP_HLT) begin
            state_r <= S_HALT;
          end else if (instr[15:12] > OP_BEQ) begin
            state_r <= S_FAULT;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt_r <= 16'd0;
          if ((opcode_r == OP_LDR) || (opcode_r == OP_STR)) begin
            state_r <= S_MEM;
          end else begin
            state_r <= boundary_next;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            wait_cnt_r <= 16'd0;
            if (opcode_r == OP_STR) begin
              state_r <= boundary_next;
            end else begin
              state_r <= S_WB;
            end
          end else if (timeout_hit) begin
            state_r <= S_FAULT;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        S_WB: begin
          state_r    <= boundary_next;
          wait_cnt_r <= 16'd0;
        end
        S_HALT:  state_r <= S_HALT;
        S_FAULT: state_r <= S_FAULT;
        default: state_r <= S_FAULT;
      endcase
    end
  end

  // Datapath strobes decoded from the current state and the latched opcode.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_sel    = 1'b0;
    immed_sel = 1'b0;
    alu_func  = ALU_PASS;
    flag_en   = 1'b0;
    w_en      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
      end
      S_EXEC: begin
        case (opcode_r)
          OP_JMP: begin
            pc_sel = 1'b1;
            pc_inc = 1'b1;
          end
          OP_ADDS, OP_SUBS, OP_ANDS, OP_ORRS, OP_ADDI: begin
            case (opcode_r)
              OP_SUBS: alu_func = ALU_SUB;
              OP_ANDS: alu_func = ALU_AND;
              OP_ORRS: alu_func = ALU_ORR;
              default: alu_func = ALU_ADD;
            endcase
            immed_sel = (opcode_r == OP_ADDI);
            w_en      = 1'b1;
            flag_en   = 1'b1;
            pc_inc    = 1'b1;
          end
          OP_BEQ: begin
            pc_sel = zero_flag;
            pc_inc = 1'b1;
          end
          OP_LDR, OP_STR: begin
            alu_func  = ALU_ADD;
            immed_sel = 1'b1;
          end
          default: begin
            pc_inc = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        // The address ALU setup is held so the address stays stable for the whole handshake.
        mem_req   = 1'b1;
        mem_sel   = 1'b1;
        mem_we    = (opcode_r == OP_STR);
        alu_func  = ALU_ADD;
        immed_sel = 1'b1;
        pc_inc    = (opcode_r == OP_STR) && mem_ack;
      end
      S_WB: begin
        w_en    = 1'b1;
        mem_sel = 1'b1;
        pc_inc  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign state = state_r;

endmodule
